// File: rtl/vdu_clock_gen.sv
// Multi-channel clock divider: NUM_CH registered divided clocks with tick strobes.
// Divisor reloads are deferred to each channel's period boundary; sync phase-aligns all channels.
module vdu_clock_gen #(
    parameter int NUM_CH  = 2,
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic                      sysclk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      sync,
    input  logic [NUM_CH*DIV_W-1:0]   cfg_div,
    input  logic                      cfg_load,
    output logic                      cfg_busy,
    output logic                      cfg_err,
    output logic [NUM_CH-1:0]         vduclk,
    output logic [NUM_CH-1:0]         tick,
    output logic                      ready
);

    localparam logic [DIV_W-1:0] DEF_RAW = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] DEF_D   = (DEF_RAW == '0) ? DIV_W'(1) : DEF_RAW;

    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_seen;
    logic [NUM_CH-1:0] r_vduclk;
    logic [NUM_CH-1:0] r_tick;
    logic              r_run;
    logic              r_err;

    logic              w_busy;
    logic              w_load_ok;

    assign w_busy    = |r_pend;
    assign w_load_ok = cfg_load & ~w_busy;

    assign cfg_busy  = w_busy;
    assign cfg_err   = r_err;
    assign vduclk    = r_vduclk;
    assign tick      = r_tick;
    assign ready     = &r_seen;

    // r_run remembers whether the previous cycle was enabled, so the first enabled edge restarts at cnt=0
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            r_run <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_run <= en;
            r_err <= cfg_load & w_busy;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DIV_W-1:0] r_div;
            logic [DIV_W-1:0] r_pdiv;
            logic [DIV_W-1:0] r_cnt;

            logic [DIV_W-1:0] w_cfg_raw;
            logic [DIV_W-1:0] w_cfg_div;
            logic             w_bound;
            logic [DIV_W-1:0] w_div_next;
            logic [DIV_W-1:0] w_pdiv_next;
            logic [DIV_W-1:0] w_cnt_next;
            logic             w_pend_next;
            logic             w_vduclk_next;
            logic             w_tick_next;

            assign w_cfg_raw = cfg_div[gi*DIV_W +: DIV_W];
            assign w_cfg_div = (w_cfg_raw == '0) ? DIV_W'(1) : w_cfg_raw;
            // Period boundary: end of a tick cycle, a sync request, or the first enabled edge
            assign w_bound   = en & (sync | ~r_run | r_tick[gi]);

            always_comb begin
                w_div_next  = r_div;
                w_pdiv_next = r_pdiv;
                w_cnt_next  = r_cnt;
                w_pend_next = r_pend[gi];
                if (!en) begin
                    w_cnt_next = '0;
                    if (r_pend[gi]) begin
                        w_div_next  = r_pdiv;
                        w_pend_next = 1'b0;
                    end
                    if (w_load_ok) begin
                        w_pdiv_next = w_cfg_div;
                        w_pend_next = 1'b1;
                    end
                end else if (w_bound) begin
                    w_cnt_next  = '0;
                    w_pend_next = 1'b0;
                    if (w_load_ok) begin
                        w_div_next = w_cfg_div;
                    end else if (r_pend[gi]) begin
                        w_div_next = r_pdiv;
                    end
                end else begin
                    w_cnt_next = r_cnt + DIV_W'(1);
                    if (w_load_ok) begin
                        w_pdiv_next = w_cfg_div;
                        w_pend_next = 1'b1;
                    end
                end
            end

            assign w_vduclk_next = en & ((w_div_next == DIV_W'(1)) | (w_cnt_next < (w_div_next >> 1)));
            assign w_tick_next   = en & (w_cnt_next == (w_div_next - DIV_W'(1)));

            always_ff @(posedge sysclk or negedge rst) begin
                if (!rst) begin
                    r_div        <= DEF_D;
                    r_pdiv       <= DEF_D;
                    r_cnt        <= '0;
                    r_pend[gi]   <= 1'b0;
                    r_seen[gi]   <= 1'b0;
                    r_vduclk[gi] <= 1'b0;
                    r_tick[gi]   <= 1'b0;
                end else begin
                    r_div        <= w_div_next;
                    r_pdiv       <= w_pdiv_next;
                    r_cnt        <= w_cnt_next;
                    r_pend[gi]   <= w_pend_next;
                    r_seen[gi]   <= en & (r_seen[gi] | r_tick[gi]);
                    r_vduclk[gi] <= w_vduclk_next;
                    r_tick[gi]   <= w_tick_next;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_vdu_clock_gen.sv
// Scoreboard bench for vdu_clock_gen: directed per-cycle vectors push expected outputs,
// a monitor pops and compares one vector per cycle on the falling edge.
module tb_vdu_clock_gen;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 8;

    logic                    sysclk = 1'b0;
    logic                    rst    = 1'b0;
    logic                    en     = 1'b0;
    logic                    sync   = 1'b0;
    logic                    cfg_load = 1'b0;
    logic [NUM_CH*DIV_W-1:0] cfg_div = '0;
    logic                    cfg_busy;
    logic                    cfg_err;
    logic [NUM_CH-1:0]       vduclk;
    logic [NUM_CH-1:0]       tick;
    logic                    ready;

    vdu_clock_gen #(
        .NUM_CH  (NUM_CH),
        .DIV_W   (DIV_W),
        .DEF_DIV (2)
    ) dut (
        .sysclk   (sysclk),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .cfg_div  (cfg_div),
        .cfg_load (cfg_load),
        .cfg_busy (cfg_busy),
        .cfg_err  (cfg_err),
        .vduclk   (vduclk),
        .tick     (tick),
        .ready    (ready)
    );

    always #5 sysclk = ~sysclk;

    typedef struct packed {
        logic [1:0] v;
        logic [1:0] t;
        logic       b;
        logic       e;
        logic       r;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_x;
    logic [6:0] mon_got;
    int n_vec = 0;
    int n_bad = 0;

    // One vector per cycle: drive inputs, optionally pulse reset between edges, queue the expected state
    task automatic step(input logic r_n, input logic e_in, input logic s_in, input logic ld,
                        input int d1, input int d0,
                        input logic [1:0] v, input logic [1:0] t,
                        input logic b, input logic er, input logic rd, input logic glitch);
        exp_t x;
        rst      = r_n;
        en       = e_in;
        sync     = s_in;
        cfg_load = ld;
        cfg_div  = {8'(d1), 8'(d0)};
        if (glitch) begin
            @(negedge sysclk);
            #1 rst = 1'b0;
            #2 rst = 1'b1;
        end
        @(posedge sysclk);
        x.v = v; x.t = t; x.b = b; x.e = er; x.r = rd;
        exp_q.push_back(x);
        #1;
    endtask

    initial begin : monitor
        forever begin
            @(negedge sysclk);
            if (exp_q.size() > 0) begin
                mon_x   = exp_q.pop_front();
                mon_got = {vduclk, tick, cfg_busy, cfg_err, ready};
                n_vec++;
                if (mon_got !== mon_x) begin
                    n_bad++;
                    $display("FAIL vec%0d: got vduclk=%b tick=%b busy=%b err=%b ready=%b, want vduclk=%b tick=%b busy=%b err=%b ready=%b",
                             n_vec, vduclk, tick, cfg_busy, cfg_err, ready,
                             mon_x.v, mon_x.t, mon_x.b, mon_x.e, mon_x.r);
                end else begin
                    $display("vec%0d ok: vduclk=%b tick=%b busy=%b err=%b ready=%b",
                             n_vec, vduclk, tick, cfg_busy, cfg_err, ready);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        //      rst en sy ld d1 d0   vduclk tick  busy err rdy glitch
        // reset and start-up at DEF_DIV=2
        step(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 1, 0);
        // load in tick cycle applies next edge: ch0=4, ch1=2
        step(1, 1, 0, 1, 2, 4, 2'b11, 2'b00, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 1, 0);
        // reload ch0=6 at cnt=1: two more cycles at D=4 then 3 high / 3 low
        step(1, 1, 0, 1, 2, 6, 2'b10, 2'b00, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b00, 2'b11, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 1, 0);
        // sync+load immediate apply: ch0=5 (2 high / 3 low), ch1=1 (always high, tick every cycle)
        step(1, 1, 1, 1, 1, 5, 2'b11, 2'b10, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b11, 2'b10, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b10, 2'b10, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b10, 2'b10, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b10, 2'b11, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b11, 2'b10, 0, 0, 1, 0);
        // loading 0 acts as 1
        step(1, 1, 0, 1, 0, 0, 2'b11, 2'b10, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b10, 2'b10, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b10, 2'b10, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b10, 2'b11, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b11, 2'b11, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b11, 2'b11, 0, 0, 1, 0);
        // busy collision: pending 6/3 survives a rejected 8/8 load
        step(1, 1, 1, 1, 2, 4, 2'b11, 2'b00, 0, 0, 1, 0);
        step(1, 1, 0, 1, 3, 6, 2'b01, 2'b10, 1, 0, 1, 0);
        step(1, 1, 0, 1, 8, 8, 2'b10, 2'b00, 1, 1, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b00, 2'b01, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 1, 0);
        // sync alignment: ch0=3, ch1=4, ticks coincide 12 cycles after sync
        step(1, 1, 1, 1, 4, 3, 2'b11, 2'b00, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 1, 0);
        step(1, 1, 1, 0, 0, 0, 2'b11, 2'b00, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b10, 2'b01, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b10, 2'b01, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 1, 0);
        // disable mid-period, load while disabled, sync ignored, resume from cnt=0
        step(1, 1, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        step(1, 0, 0, 1, 2, 2, 2'b00, 2'b00, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 1, 0);
        // reset pulse between edges while busy: pending 9/9 lost, D back to 2
        step(1, 1, 0, 1, 9, 9, 2'b00, 2'b11, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 1, 0);

        repeat (3) @(posedge sysclk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
